fmc_slave_bridge: RTL

FPGA-side responder for the STM32 FMC asynchronous NOR/SRAM-style bus (bank 1 chip select). It synchronises the MCU's strobes into `clk`, turns each FMC access into a single-cycle internal register-bus write or read, and stretches reads with `fmc_nwait` until the register file answers. It sits between the board-level FMC pins and the FPGA's CSR fabric.

---
 rtl/fmc_pkg.sv | 19 +
 rtl/fmc_sync.sv | 30 +++
 rtl/fmc_slave_bridge.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fmc_pkg.sv
// ---------------------------------------------------------------------------
// fmc_pkg: shared state encoding and constants for the FMC slave bridge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_DRIVE = 2'd2,
    ST_DONE     = 2'd3
  } fmc_state_t;

  localparam logic [31:0] FMC_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/fmc_sync.sv
// ---------------------------------------------------------------------------
// fmc_sync: single-bit N-stage synchroniser with a parameterised reset value. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fmc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fmc_slave_bridge.sv
// ---------------------------------------------------------------------------
// fmc_slave_bridge: STM32 FMC async bus responder to single-cycle register bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fmc_slave_bridge
  import fmc_pkg::*;
#(
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] fmc_a,
  inout  wire  [DATA_BITS-1:0] fmc_d,
  input  logic                 fmc_ne1,
  input  logic                 fmc_noe,
  input  logic                 fmc_nwe,
  output logic                 fmc_nwait,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic [DATA_BITS-1:0] reg_wdata,
  output logic                 reg_wr,
  output logic                 reg_rd,
  input  logic [DATA_BITS-1:0] reg_rdata,
  input  logic                 reg_rack,
  output logic                 err_timeout
);

  localparam int              CNT_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

  logic [2:0]           strobe_raw;
  logic [2:0]           strobe_s;
  logic                 ne1_s;
  logic                 noe_s;
  logic                 nwe_s;
  fmc_state_t           state;
  logic [CNT_W-1:0]     rd_cnt;
  logic [CNT_W-1:0]     rd_cnt_inc;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 nwait_q;
  logic                 drive_en;

  assign strobe_raw = {fmc_nwe, fmc_noe, fmc_ne1};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    fmc_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (strobe_raw[i]),
      .q     (strobe_s[i])
    );
  end

  assign ne1_s = strobe_s[0];
  assign noe_s = strobe_s[1];
  assign nwe_s = strobe_s[2];

  // Saturating increment so a stuck read can never wrap back into range.
  assign rd_cnt_inc = (rd_cnt == CNT_MAX) ? rd_cnt : rd_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_cnt      <= '0;
      rdata_q     <= '0;
      nwait_q     <= 1'b1;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!ne1_s && !nwe_s) begin
            reg_addr  <= fmc_a;
            reg_wdata <= fmc_d;
            reg_wr    <= 1'b1;
            state     <= ST_DONE;
          end else if (!ne1_s && !noe_s) begin
            reg_addr <= fmc_a;
            reg_rd   <= 1'b1;
            nwait_q  <= 1'b0;
            rd_cnt   <= '0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          rd_cnt <= rd_cnt_inc;
          if (reg_rack) begin
            rdata_q <= reg_rdata;
            nwait_q <= 1'b1;
            state   <= ST_RD_DRIVE;
          end else if (rd_cnt_inc == CNT_MAX) begin
            rdata_q     <= DATA_BITS'(FMC_TIMEOUT_DATA);
            nwait_q     <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_RD_DRIVE;
          end
        end
        ST_RD_DRIVE: begin
          if (noe_s || ne1_s) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ne1_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Raw pins gate the driver so the bus frees as soon as the MCU drops OE.
  assign drive_en  = (state == ST_RD_DRIVE) && !fmc_noe && !fmc_ne1;
  assign fmc_d     = drive_en ? rdata_q : {DATA_BITS{1'bz}};
  assign fmc_nwait = nwait_q;

endmodule

`default_nettype wire
